// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT datapath.
// Holds the butterfly pipeline depth, a generic complex-sample container and
// width-parametrised rounding / saturation helpers. The helpers work on a
// 64-bit signed carrier and take the target width or shift as an argument,
// so callers pick the width at the call site.
package fft_pkg;

  localparam int BFLY_LAT   = 3;
  localparam int CPLX_MAX_W = 32;

  typedef struct packed {
    logic signed [CPLX_MAX_W-1:0] re;
    logic signed [CPLX_MAX_W-1:0] im;
  } cplx_t;

  // Round-half-up arithmetic right shift: add half an LSB of the result, then shift.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
    logic signed [63:0] bias;
    bias = 64'sd1 <<< (sh - 1);
    return (v + bias) >>> sh;
  endfunction

  // True when v lies outside the signed range of a w-bit word.
  function automatic logic is_sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  // Clamp v into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/bfly_round_sat.sv
// bfly_round_sat: scales a wide twiddle-product sum back to sample range.
// Shifts right by SHIFT (one more when i_scale is set) with round-half-up,
// then saturates to OUT_W signed bits. o_sat flags that clamping happened.
module bfly_round_sat
  import fft_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int OUT_W = 17,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  i_val,
  input  logic                    i_scale,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_sat
);

  logic signed [63:0] w_rnd;

  // Round the sum at the selected shift, then clamp and report the clamp.
  always_comb begin
    w_rnd = round_shift(64'(i_val), i_scale ? SHIFT + 1 : SHIFT);
    o_sat = is_sat(w_rnd, OUT_W);
    o_val = OUT_W'(sat_clip(w_rnd, OUT_W));
  end

endmodule

// File: rtl/butterfly_r2_pipe.sv
// butterfly_r2_pipe: three-stage radix-2 DIF butterfly with valid/ready.
//   Y0 = X0 + X1, Y1 = (X0 - X1) * (cos - j*sin)
// Stage 1 forms exact sum/difference, stage 2 the four twiddle products,
// stage 3 combines, rounds and saturates into the output register.
// A single enable freezes every stage while the output is held.
// Optional: define BFLY_OVF_STICKY_EN to add the sticky ovf flag with ovf_clr.
module butterfly_r2_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x0_re,
  input  logic signed [DATA_W-1:0] x0_im,
  input  logic signed [DATA_W-1:0] x1_re,
  input  logic signed [DATA_W-1:0] x1_im,
  input  logic signed [TW_W-1:0]   tw_cos,
  input  logic signed [TW_W-1:0]   tw_sin,
  input  logic                     scale,
  input  logic [TAG_W-1:0]         tag_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W:0]   y0_re,
  output logic signed [DATA_W:0]   y0_im,
  output logic signed [DATA_W:0]   y1_re,
  output logic signed [DATA_W:0]   y1_im,
  output logic [TAG_W-1:0]         tag_out
`ifdef BFLY_OVF_STICKY_EN
  ,
  output logic                     ovf,
  input  logic                     ovf_clr
`endif
);

  localparam int YW = DATA_W + 1;
  localparam int PW = DATA_W + TW_W + 1;
  localparam int SW = DATA_W + TW_W + 2;

  logic w_ce;

  logic                   r_v1;
  logic signed [YW-1:0]   r_s0_re;
  logic signed [YW-1:0]   r_s0_im;
  logic signed [YW-1:0]   r_d_re;
  logic signed [YW-1:0]   r_d_im;
  logic signed [TW_W-1:0] r_cos;
  logic signed [TW_W-1:0] r_sin;
  logic                   r_scale1;
  logic [TAG_W-1:0]       r_tag1;

  logic                   r_v2;
  logic signed [PW-1:0]   r_p_rc;
  logic signed [PW-1:0]   r_p_rs;
  logic signed [PW-1:0]   r_p_ic;
  logic signed [PW-1:0]   r_p_is;
  logic signed [YW-1:0]   r_s0_re2;
  logic signed [YW-1:0]   r_s0_im2;
  logic                   r_scale2;
  logic [TAG_W-1:0]       r_tag2;

  logic                   r_out_valid;
  logic signed [YW-1:0]   r_y0_re;
  logic signed [YW-1:0]   r_y0_im;
  logic signed [YW-1:0]   r_y1_re;
  logic signed [YW-1:0]   r_y1_im;
  logic [TAG_W-1:0]       r_tag_out;

  logic signed [SW-1:0]   w_re;
  logic signed [SW-1:0]   w_im;
  logic signed [YW-1:0]   w_y0_re;
  logic signed [YW-1:0]   w_y0_im;
  logic signed [YW-1:0]   w_y1_re;
  logic signed [YW-1:0]   w_y1_im;
  logic                   w_sat_re;
  logic                   w_sat_im;

  // The pipe moves whenever the output slot is empty or being drained.
  assign w_ce     = !r_out_valid || out_ready;
  assign in_ready = w_ce;

  // Stage 1: exact sum and difference, twiddle/scale/tag captured alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_s0_re  <= '0;
      r_s0_im  <= '0;
      r_d_re   <= '0;
      r_d_im   <= '0;
      r_cos    <= '0;
      r_sin    <= '0;
      r_scale1 <= 1'b0;
      r_tag1   <= '0;
    end else if (w_ce) begin
      r_v1     <= in_valid;
      r_s0_re  <= YW'(x0_re) + YW'(x1_re);
      r_s0_im  <= YW'(x0_im) + YW'(x1_im);
      r_d_re   <= YW'(x0_re) - YW'(x1_re);
      r_d_im   <= YW'(x0_im) - YW'(x1_im);
      r_cos    <= tw_cos;
      r_sin    <= tw_sin;
      r_scale1 <= scale;
      r_tag1   <= tag_in;
    end
  end

  // Stage 2: the four difference-by-twiddle products, sum delayed to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2     <= 1'b0;
      r_p_rc   <= '0;
      r_p_rs   <= '0;
      r_p_ic   <= '0;
      r_p_is   <= '0;
      r_s0_re2 <= '0;
      r_s0_im2 <= '0;
      r_scale2 <= 1'b0;
      r_tag2   <= '0;
    end else if (w_ce) begin
      r_v2     <= r_v1;
      r_p_rc   <= PW'(r_d_re) * PW'(r_cos);
      r_p_rs   <= PW'(r_d_re) * PW'(r_sin);
      r_p_ic   <= PW'(r_d_im) * PW'(r_cos);
      r_p_is   <= PW'(r_d_im) * PW'(r_sin);
      r_s0_re2 <= r_s0_re;
      r_s0_im2 <= r_s0_im;
      r_scale2 <= r_scale1;
      r_tag2   <= r_tag1;
    end
  end

  // Stage 3 combine: multiply by (cos - j*sin), and halve Y0 with rounding on scaled beats.
  always_comb begin
    w_re    = SW'(r_p_rc) + SW'(r_p_is);
    w_im    = SW'(r_p_ic) - SW'(r_p_rs);
    w_y0_re = r_s0_re2;
    w_y0_im = r_s0_im2;
    if (r_scale2) begin
      w_y0_re = YW'(round_shift(64'(r_s0_re2), 1));
      w_y0_im = YW'(round_shift(64'(r_s0_im2), 1));
    end
  end

  bfly_round_sat #(
    .IN_W  (SW),
    .OUT_W (YW),
    .SHIFT (TW_W - 1)
  ) u_rs_re (
    .i_val   (w_re),
    .i_scale (r_scale2),
    .o_val   (w_y1_re),
    .o_sat   (w_sat_re)
  );

  bfly_round_sat #(
    .IN_W  (SW),
    .OUT_W (YW),
    .SHIFT (TW_W - 1)
  ) u_rs_im (
    .i_val   (w_im),
    .i_scale (r_scale2),
    .o_val   (w_y1_im),
    .o_sat   (w_sat_im)
  );

  // Output register: holds its contents while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y0_re     <= '0;
      r_y0_im     <= '0;
      r_y1_re     <= '0;
      r_y1_im     <= '0;
      r_tag_out   <= '0;
    end else if (w_ce) begin
      r_out_valid <= r_v2;
      r_y0_re     <= w_y0_re;
      r_y0_im     <= w_y0_im;
      r_y1_re     <= w_y1_re;
      r_y1_im     <= w_y1_im;
      r_tag_out   <= r_tag2;
    end
  end

  assign out_valid = r_out_valid;
  assign y0_re     = r_y0_re;
  assign y0_im     = r_y0_im;
  assign y1_re     = r_y1_re;
  assign y1_im     = r_y1_im;
  assign tag_out   = r_tag_out;

`ifdef BFLY_OVF_STICKY_EN
  logic r_ovf;

  // Sticky flag: a valid saturating beat entering the output sets it, and beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ce && r_v2 && (w_sat_re || w_sat_im)) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_sat_re | w_sat_im;
`endif

endmodule

// File: doc/butterfly_r2_pipe.md
# butterfly_r2_pipe

Pipelined, parametrised radix-2 DIF butterfly with valid/ready flow control, per-sample scaling, rounding and saturation. It computes Y0 = X0 + X1 and Y1 = (X0 − X1)·W, with W = cos − j·sin. It is the per-stage compute element of the FFT datapath, fed by the stage's address/twiddle sequencer, and replaces the single-register butterfly. Data is widened, never truncated silently.

## Interface
- DATA_W, 16: input sample width, signed, per real/imag component.
- TW_W, 16: twiddle width, signed Q1.(TW_W−1).
- TAG_W, 8: sideband tag width (sample index), passed through unchanged.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- x0_re, x0_im, x1_re, x1_im  in  DATA_W each  signed input operands.
- tw_cos, tw_sin  in  TW_W each  signed twiddle.
- scale  in  1  1 = halve both outputs for this beat.
- tag_in  in  TAG_W  sideband.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- y0_re, y0_im, y1_re, y1_im  out  DATA_W+1 each  signed results.
- tag_out  out  TAG_W  tag aligned with results.
- ovf  out  1  sticky saturation flag (present only with BFLY_OVF_STICKY_EN).
- ovf_clr  in  1  clears ovf (present only with BFLY_OVF_STICKY_EN).

## Operation
- S1 register: s0 = x0 + x1 and d = x0 − x1, both DATA_W+1 bits and exact. Also registers the twiddle, scale and tag.
- S2 register: four products d·cos and d·sin, each DATA_W+TW_W+1 bits. s0 is delayed alongside them.
- S3 combine, output register:
  - re = d_re·cos + d_im·sin; im = d_im·cos − d_re·sin. Both are DATA_W+TW_W+2 bits.
  - Shift right by TW_W−1, plus 1 more if scale=1.
  - Rounding: round-half-up, implemented by adding 2^(shift−1) before an arithmetic shift.
  - Saturate to the DATA_W+1 signed range [−2^DATA_W, 2^DATA_W−1].
  - Y0 with scale=1: (s0 + 1) >>> 1. With scale=0 it passes unchanged. Y0 can never saturate.
- Twiddle −1.0 (−2^(TW_W−1)) is legal and must produce correct results.
- Flow control:
  - Global enable: ce = !out_valid | out_ready; in_ready = ce.
  - All stage registers and valid bits advance only when ce = 1.
  - A beat transfers when in_valid & in_ready.
  - The output holds stable while out_valid & !out_ready.
- Bubbles: invalid beats propagate as bubbles. Data registers may update on bubbles, but out_valid must be 0 for them.
- Reset: all valid bits, outputs, tag_out and ovf go to 0. A reset during operation discards every in-flight beat.

## Timing
- Latency is 3 cycles from an accepted input to out_valid, assuming no stall.
- Throughput is 1 beat per cycle while out_ready = 1.
- in_ready is combinational from out_ready and out_valid. There are no other combinational input-to-output paths.
- A stall freezes the whole pipe. The first cycle out_ready = 1 releases one beat per cycle with no loss or duplication.
- ovf sets in the cycle a saturating beat is registered into the output stage with out_valid.
- ovf_clr and a simultaneous new saturation: the set wins.

## Configuration
- BFLY_OVF_STICKY_EN defined: ovf and ovf_clr ports plus the sticky register are present.
- Not defined: both ports and the register are absent. Saturation arithmetic is identical either way.

## Structure
- Shared package fft_pkg:
  - Stage count constant (BFLY_LAT = 3).
  - Rounding/saturation helper functions, parametrised by width.
  - Complex-sample struct typedef.
- One sub-module, bfly_round_sat: shift, round and saturate, with a saturation indicator. It is instantiated twice, for Y1 real and imaginary.

## Test plan
Unless stated otherwise, DATA_W=16, TW_W=16, scale=0, out_ready=1.
- Pass-through: x0=100+0j, x1=40+0j, cos=32767, sin=0 → 3 cycles later y0=140, y1_re=60, y1_im=0, tag preserved.
- Scaling: same stimulus with scale=1 → y0=70, y1_re=30.
- Saturation:
  - x0=32767+32767j, x1=−32768−32768j, cos=sin=−32768.
  - Expected: y0=−1−1j, y1_re=−65536 (saturated), y1_im=0, ovf=1.
  - Then ovf_clr for one cycle → ovf=0.
- Backpressure: stream 10 tagged beats with out_ready toggling every 2 cycles → all 10 appear in order, none lost or duplicated, outputs stable while stalled.
- Reset: rst asserted for one cycle with 3 beats in flight → out_valid=0 and all outputs 0 next cycle. Those beats never appear.
- Random: 10k random operands and twiddles against a bit-exact reference model, including cos/sin = −32768.
